// File: rtl/usr_serializer.sv
// Parallel-to-serial converter with a valid/ready word input and a valid/ready bit output.
// The shift direction is latched with each word; done pulses in the cycle after the last bit leaves.
module usr_serializer #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             dir,
   output logic             ser_out,
   output logic             ser_valid,
   input  logic             ser_ready,
   output logic             done
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [CW-1:0]    cnt_q,   cnt_d;
   logic             dir_q,   dir_d;
   logic             done_q,  done_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         shreg_q <= '0;
         cnt_q   <= '0;
         dir_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         cnt_q   <= cnt_d;
         dir_q   <= dir_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (in_valid) state_d = SHIFT;
         SHIFT:   if (ser_ready && cnt_q == '0) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // cnt counts bits still to be consumed after the one currently on ser_out
   always_comb begin
      shreg_d = shreg_q;
      cnt_d   = cnt_q;
      dir_d   = dir_q;
      done_d  = 1'b0;
      if (state_q == IDLE) begin
         if (in_valid) begin
            shreg_d = in_data;
            dir_d   = dir;
            cnt_d   = CW'(WIDTH - 1);
         end
      end else if (ser_ready) begin
         if (cnt_q != '0) begin
            shreg_d = dir_q ? (shreg_q << 1) : (shreg_q >> 1);
            cnt_d   = cnt_q - CW'(1);
         end else begin
            done_d  = 1'b1;
         end
      end
   end

   always_comb begin
      in_ready  = 1'b0;
      ser_valid = 1'b0;
      ser_out   = 1'b0;
      done      = done_q;
      case (state_q)
         IDLE: in_ready = 1'b1;
         SHIFT: begin
            ser_valid = 1'b1;
            ser_out   = dir_q ? shreg_q[WIDTH-1] : shreg_q[0];
         end
         default: in_ready = 1'b0;
      endcase
   end

endmodule

// File: tb/tb_usr_serializer.sv
// Bench for usr_serializer (WIDTH=4): directed scenarios plus random traffic,
// checked every cycle against a queue-of-pending-bits reference model.
module tb_usr_serializer;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst, in_valid, dir, ser_ready;
   logic [W-1:0] in_data;
   logic         in_ready, ser_out, ser_valid, done;

   usr_serializer #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .dir(dir), .ser_out(ser_out), .ser_valid(ser_valid),
      .ser_ready(ser_ready), .done(done)
   );

   always #5 clk = ~clk;

   int   n_vec = 0;
   int   n_bad = 0;
   bit   m_bits[$];
   bit   m_done = 1'b0;
   logic [31:0] cons;
   int   hs_cnt;
   int   gap_cnt;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference: an accepted word becomes a queue of bits in emission order.
   task automatic model_edge();
      if (rst) begin
         m_bits.delete();
         m_done = 1'b0;
      end else if (m_bits.size() == 0) begin
         m_done = 1'b0;
         if (in_valid) begin
            for (int i = 0; i < W; i++)
               m_bits.push_back(dir ? in_data[W-1-i] : in_data[i]);
         end
      end else if (ser_ready) begin
         void'(m_bits.pop_front());
         m_done = (m_bits.size() == 0);
      end else begin
         m_done = 1'b0;
      end
   endtask

   task automatic advance();
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   // Compare outputs mid-cycle, record consumed bits, then step one clock.
   task automatic tick();
      chk("in_ready",  {31'd0, in_ready},  {31'd0, m_bits.size() == 0});
      chk("ser_valid", {31'd0, ser_valid}, {31'd0, m_bits.size() != 0});
      chk("ser_out",   {31'd0, ser_out},   {31'd0, (m_bits.size() != 0) ? m_bits[0] : 1'b0});
      chk("done",      {31'd0, done},      {31'd0, m_done});
      if (ser_valid && ser_ready) begin
         cons = {cons[30:0], ser_out};
         hs_cnt++;
      end
      advance();
   endtask

   task automatic accept(input logic [W-1:0] d, input logic dr);
      in_valid = 1'b1; in_data = d; dir = dr;
      tick();
      in_valid = 1'b0; in_data = ~d; dir = ~dr;
      cons = '0; hs_cnt = 0;
   endtask

   initial begin
      logic [6:0] rdy_pat;
      rst = 1'b1; in_valid = 1'b0; in_data = '0; dir = 1'b0; ser_ready = 1'b0;
      cons = '0; hs_cnt = 0; gap_cnt = 0;
      @(negedge clk);
      advance();
      advance();
      rst = 1'b0;
      tick();

      // LSB first, 1011 -> 1,1,0,1 then done with in_ready
      ser_ready = 1'b1;
      accept(4'b1011, 1'b0);
      repeat (4) tick();
      chk("lsb_seq", cons, 32'b1101);
      chk("lsb_done", {31'd0, done}, 32'd1);
      chk("lsb_done_rdy", {31'd0, in_ready}, 32'd1);
      tick();
      chk("lsb_done_once", {31'd0, done}, 32'd0);

      // MSB first, 1011 -> 1,0,1,1
      accept(4'b1011, 1'b1);
      repeat (4) tick();
      chk("msb_seq", cons, 32'b1011);
      chk("msb_done", {31'd0, done}, 32'd1);
      tick();

      // Backpressure: ready pattern 1,0,0,1,1,0,1
      rdy_pat = 7'b1001101;
      accept(4'b0110, 1'b0);
      for (int i = 6; i >= 0; i--) begin
         ser_ready = rdy_pat[i];
         tick();
      end
      chk("bp_seq", cons, 32'b0110);
      chk("bp_hs", hs_cnt, 32'd4);
      ser_ready = 1'b1;
      tick();

      // Reset after two consumed bits aborts the word
      accept(4'b1001, 1'b0);
      repeat (2) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
      chk("rst_ser_valid", {31'd0, ser_valid}, 32'd0);
      chk("rst_ser_out",   {31'd0, ser_out},   32'd0);
      chk("rst_done",      {31'd0, done},      32'd0);
      hs_cnt = 0;
      repeat (4) tick();
      chk("rst_no_bits", hs_cnt, 32'd0);

      // Word offered during SHIFT is ignored until the done cycle
      accept(4'b0001, 1'b0);
      in_valid = 1'b1; in_data = 4'b1111; dir = 1'b0;
      repeat (4) tick();
      chk("hold_seq", cons, 32'b1000);
      chk("hold_acc_rdy", {31'd0, in_ready}, 32'd1);
      chk("hold_acc_done", {31'd0, done}, 32'd1);
      tick();
      in_valid = 1'b0;
      cons = '0; hs_cnt = 0;
      repeat (4) tick();
      chk("hold_second", cons, 32'b1111);
      tick();

      // Back-to-back words with in_valid held high
      in_valid = 1'b1; in_data = 4'hA; dir = 1'b0;
      tick();
      in_data = 4'h5;
      cons = '0; hs_cnt = 0; gap_cnt = 0;
      for (int i = 0; i < 9; i++) begin
         if (!ser_valid) gap_cnt++;
         if (i == 4) in_valid = 1'b1;
         tick();
         if (i == 4) in_valid = 1'b0;
      end
      chk("b2b_seq", cons, 32'b01011010);
      chk("b2b_gap", gap_cnt, 32'd1);
      tick();

      // Random traffic against the model
      for (int i = 0; i < 400; i++) begin
         rst       = ($urandom_range(0, 59) == 0);
         in_valid  = $urandom_range(0, 1);
         in_data   = W'($urandom);
         dir       = $urandom_range(0, 1);
         ser_ready = ($urandom_range(0, 3) != 0);
         tick();
      end
      rst = 1'b0; in_valid = 1'b0; ser_ready = 1'b1;
      repeat (6) tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/usr_serializer.md
USR_SERIALIZER -- requirements
Module: usr_serializer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the parallel word width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit, reset; it is synchronous and active-high.
REQ-004 The block SHALL have port in_valid, input, 1 bit, meaning a parallel word is offered.
REQ-005 The block SHALL have port in_ready, output, 1 bit, meaning the block can accept a word this cycle.
REQ-006 The block SHALL have port in_data, input, WIDTH bits, the parallel word.
REQ-007 The block SHALL have port dir, input, 1 bit, the shift direction: 0 = LSB first (shift right), 1 = MSB first (shift left).
REQ-008 The block SHALL have port ser_out, output, 1 bit, the current serial bit.
REQ-009 The block SHALL have port ser_valid, output, 1 bit, meaning ser_out holds a valid bit.
REQ-010 The block SHALL have port ser_ready, input, 1 bit, meaning downstream consumes ser_out this cycle.
REQ-011 The block SHALL have port done, output, 1 bit, a one-cycle pulse after the last bit of a word is consumed.

Function
REQ-012 The block SHALL implement two states: IDLE and SHIFT.
REQ-013 In IDLE, the block SHALL drive in_ready=1, ser_valid=0 and ser_out=0.
REQ-014 In SHIFT, the block SHALL drive in_ready=0 and ser_valid=1.
REQ-015 On a clock edge in IDLE with in_valid=1, the block SHALL perform all of: shreg <= in_data, dir_q <= dir, cnt <= WIDTH-1, state <= SHIFT.
REQ-016 The block SHALL present the first serial bit in the cycle immediately after acceptance (latency 1 cycle).
REQ-017 In SHIFT, ser_out SHALL equal shreg[0] when dir_q=0 and shreg[WIDTH-1] when dir_q=1.
REQ-018 On an edge in SHIFT with ser_ready=1 and cnt!=0, the block SHALL shift shreg one place toward the output end, fill the vacated bit with 0, and decrement cnt.
REQ-019 On an edge in SHIFT with ser_ready=1 and cnt==0, the block SHALL set state <= IDLE and register done=1 for exactly the following cycle.
REQ-020 On an edge in SHIFT with ser_ready=0, shreg, cnt and state SHALL hold, and ser_out SHALL remain stable.
REQ-021 The block SHALL drive done=0 in every cycle other than the one specified in REQ-019.
REQ-022 While in SHIFT, in_valid, in_data and dir SHALL be ignored; no word is lost or overwritten.
REQ-023 The cycle in which done=1 SHALL also be an IDLE cycle with in_ready=1, so that a word held on in_valid is accepted back-to-back with no idle gap beyond that cycle.
REQ-024 Changes to in_data or dir after acceptance SHALL NOT affect the word being serialized.
REQ-025 The block SHALL emit exactly WIDTH ser_valid&&ser_ready handshakes per accepted word.

Reset
REQ-026 When rst=1 at an edge, the block SHALL set state=IDLE, shreg=0, cnt=0, dir_q=0 and done=0, overriding all other inputs.
REQ-027 Following a reset, the outputs SHALL be in_ready=1, ser_valid=0, ser_out=0 and done=0 in the next cycle.
REQ-028 A reset asserted mid-SHIFT SHALL abort the word; remaining bits SHALL NOT be emitted and done SHALL NOT pulse.

Verification (WIDTH=4)
REQ-029 The bench SHALL apply in_data=4'b1011, dir=0, ser_ready=1 and check ser_out=1,1,0,1 on four consecutive cycles, then done=1 for one cycle with in_ready=1.
REQ-030 The bench SHALL apply in_data=4'b1011, dir=1, ser_ready=1 and check ser_out=1,0,1,1, followed by a single done pulse.
REQ-031 The bench SHALL apply 4'b0110 with dir=0 and ser_ready toggling 1,0,0,1,1,0,1, and check that ser_out holds during ser_ready=0 and that the consumed sequence is exactly 0,1,1,0.
REQ-032 The bench SHALL assert rst for one cycle after 2 bits are consumed and check that the next cycle shows in_ready=1, ser_valid=0, ser_out=0, done=0 and no further bits.
REQ-033 The bench SHALL present in_valid=1 with in_data=4'b1111 during SHIFT of 4'b0001 and check that the output is 1,0,0,0 unchanged and that 4'b1111 is accepted only in the done cycle.
REQ-034 The bench SHALL hold in_valid=1 continuously with words 4'hA then 4'h5 at dir=0 and check the stream 0,1,0,1,1,0,1,0, with exactly one cycle of ser_valid=0 between words.
